// File: rtl/delay_pipe_sink.sv
// delay_pipe_sink: credit-gated receive FIFO that terminates a
// fixed-latency, non-stallable delay pipe.
module delay_pipe_sink #(
  parameter  int N  = 5,
  parameter  int W  = 32,
  parameter  int D  = N + 2,
  localparam int CW = $clog2(D + 1),
  localparam int PW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          issue_rdy,
  input  logic          issue,
  input  logic          in_vld,
  input  logic [W-1:0]  in,
  output logic          out_vld,
  output logic [W-1:0]  out,
  input  logic          out_rdy,
  output logic [CW-1:0] credit_r,
  output logic          err_r
);

  if (D < 1 || N < 0) begin : g_bad_param
    $error("delay_pipe_sink: need D >= 1 and N >= 0");
  end

  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          err_q, err_d;
  logic [W-1:0]  mem_q [D];

  logic pop, full, push_ok;
  logic iss_ok, iss_bad, ovf;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign issue_rdy = credit_q != '0;
  assign out_vld   = cnt_q != '0;
  assign full      = cnt_q == CW'(D);
  assign pop       = out_vld & out_rdy;
  // a full FIFO still accepts when the head leaves on the same edge
  assign push_ok   = in_vld & (~full | pop);
  assign iss_ok    = issue & issue_rdy;
  assign iss_bad   = issue & ~issue_rdy;
  assign ovf       = pop & ~iss_ok & (credit_q == CW'(D));
  assign out       = mem_q[rd_q];
  assign credit_r  = credit_q;
  assign err_r     = err_q;

  always_comb begin
    credit_d = credit_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    err_d    = err_q;
    unique case (1'b1)
      iss_ok & ~pop:        credit_d = credit_q - CW'(1);
      pop & ~iss_ok & ~ovf: credit_d = credit_q + CW'(1);
      default: ;
    endcase
    unique case (1'b1)
      push_ok & ~pop: cnt_d = cnt_q + CW'(1);
      pop & ~push_ok: cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
    if (push_ok) wr_d = nxt(wr_q);
    if (pop)     rd_d = nxt(rd_q);
    err_d = err_q | iss_bad | (in_vld & ~push_ok) | ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CW'(D);
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= in;
  end

`ifndef SYNTHESIS
  int infl_q;
  always_ff @(posedge clk) begin
    if (rst) infl_q <= 0;
    else     infl_q <= infl_q + int'(iss_ok) - int'(in_vld);
    if (!rst && !err_q)
      assert (int'(credit_q) + int'(cnt_q) + infl_q == D)
        else $error("credit + occupancy + in-flight != D");
  end
`endif

endmodule

// File: tb/tb_delay_pipe_sink.sv
// tb_delay_pipe_sink: delay-pipe model upstream, queue scoreboard
// downstream, directed phases for stream, fill, errors, reset, wrap.
module tb_delay_pipe_sink;
  localparam int N  = 5;
  localparam int W  = 32;
  localparam int D  = N + 2;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_rdy;
  logic          issue = 1'b0;
  logic          in_vld;
  logic [W-1:0]  in_d;
  logic          out_vld;
  logic [W-1:0]  out_d;
  logic          out_rdy = 1'b0;
  logic [CW-1:0] credit_r;
  logic          err_r;

  logic          pipe_en  = 1'b1;
  logic          frc_vld  = 1'b0;
  logic [W-1:0]  frc_data = '0;
  logic [W-1:0]  iss_data = '0;
  logic [N-1:0]  pv;
  logic [W-1:0]  pd [N];

  logic [W-1:0]  sb [$];
  int n_chk = 0;
  int n_fail = 0;
  int n_pop = 0;
  int dcnt = 100;

  delay_pipe_sink #(.N(N), .W(W), .D(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .issue_rdy(issue_rdy),
    .issue    (issue),
    .in_vld   (in_vld),
    .in       (in_d),
    .out_vld  (out_vld),
    .out      (out_d),
    .out_rdy  (out_rdy),
    .credit_r (credit_r),
    .err_r    (err_r)
  );

  always #5 clk = ~clk;

  // upstream delay pipe: N register stages, flushed by reset
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[N-2:0], issue & pipe_en};
    pd[0] <= iss_data;
    for (int i = 1; i < N; i++) pd[i] <= pd[i-1];
  end
  assign in_vld = pv[N-1] | frc_vld;
  assign in_d   = frc_vld ? frc_data : pd[N-1];

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_vld && out_rdy) begin
      n_pop++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got %0h, scoreboard empty", out_d);
      end else begin
        chk("pop_data", out_d, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic try_issue();
    issue    = issue_rdy;
    iss_data = dcnt;
    if (issue_rdy) begin
      sb.push_back(dcnt);
      dcnt++;
    end
  endtask

  task automatic fill();
    out_rdy = 1'b0;
    for (int s = 0; s < 2 * D + N; s++) begin
      try_issue();
      step();
    end
    issue = 1'b0;
  endtask

  task automatic drain(string nm, int p0, int exp_n);
    int k = 0;
    out_rdy = 1'b1;
    while (sb.size() != 0 && k < 60) begin
      step();
      k++;
    end
    step();
    step();
    chk({nm, "_pops"}, n_pop - p0, exp_n);
    chk({nm, "_credit"}, credit_r, D);
    chk({nm, "_empty"}, out_vld, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int first;
    int acc;
    int k;
    logic [W-1:0] head;

    repeat (2) step();
    rst = 1'b0;
    chk("rst_rdy", issue_rdy, 1);
    chk("rst_credit", credit_r, D);
    chk("rst_vld", out_vld, 0);
    chk("rst_err", err_r, 0);

    // streaming at full rate
    p0 = n_pop;
    first = -1;
    out_rdy = 1'b1;
    for (int s = 0; s < 30; s++) begin
      chk("stream_rdy", issue_rdy, 1);
      try_issue();
      step();
      if (out_vld && first < 0) first = s;
      if (s >= N) chk("stream_credit", credit_r, 1);
    end
    issue = 1'b0;
    chk("stream_fill", first, N);
    drain("stream", p0, 30);
    chk("stream_err", err_r, 0);

    // backpressure fill
    p0 = n_pop;
    acc = 0;
    out_rdy = 1'b0;
    for (int s = 0; s < 15; s++) begin
      if (issue_rdy) acc++;
      try_issue();
      step();
      if (s == D - 1) chk("bp_rdy_after_last", issue_rdy, 0);
    end
    issue = 1'b0;
    chk("bp_accepted", acc, D);
    chk("bp_credit", credit_r, 0);
    chk("bp_vld", out_vld, 1);
    drain("bp", p0, D);
    chk("bp_err", err_r, 0);

    // push and pop together while full
    p0 = n_pop;
    fill();
    chk("full_rdy", issue_rdy, 0);
    out_rdy  = 1'b1;
    frc_vld  = 1'b1;
    frc_data = 32'hF00D_0001;
    sb.push_back(frc_data);
    step();
    frc_vld = 1'b0;
    out_rdy = 1'b0;
    chk("pp_err", err_r, 0);
    chk("pp_credit", credit_r, 1);
    chk("pp_vld", out_vld, 1);
    // spend the returned credit with nothing entering the pipe
    pipe_en = 1'b0;
    issue   = 1'b1;
    step();
    chk("spend_credit", credit_r, 0);
    chk("spend_rdy", issue_rdy, 0);
    chk("spend_err", err_r, 0);
    step();
    issue   = 1'b0;
    pipe_en = 1'b1;
    chk("ill_err", err_r, 1);
    chk("ill_credit", credit_r, 0);
    drain("pp", p0, D + 1);

    // reset with items buffered
    out_rdy = 1'b0;
    for (int s = 0; s < 4; s++) begin
      try_issue();
      step();
    end
    issue = 1'b0;
    repeat (N + 1) step();
    chk("pre_rst_vld", out_vld, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("mrst_vld", out_vld, 0);
    chk("mrst_credit", credit_r, D);
    chk("mrst_err", err_r, 0);
    chk("mrst_rdy", issue_rdy, 1);

    // stream with random consumer stalls, pointers wrap
    p0 = n_pop;
    k = 0;
    for (int s = 0; s < 300 && k < 24; s++) begin
      out_rdy = 1'($urandom_range(0, 1));
      if (issue_rdy) k++;
      try_issue();
      step();
    end
    issue = 1'b0;
    chk("wrap_issued", k, 24);
    drain("wrap", p0, 24);
    chk("wrap_err", err_r, 0);

    // overflow push while full and stalled
    p0 = n_pop;
    fill();
    head     = sb[0];
    frc_vld  = 1'b1;
    frc_data = 32'hBAD0_0BAD;
    step();
    frc_vld = 1'b0;
    chk("ovf_err", err_r, 1);
    chk("ovf_head", out_d, head);
    chk("ovf_vld", out_vld, 1);
    chk("ovf_credit", credit_r, 0);
    drain("ovf", p0, D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_pipe_sink.md
# delay_pipe_sink

Receive-side terminator for a fixed-latency, non-stallable delay pipe. Upstream logic issues into the delay pipe only when this block grants a credit. Results emerging from the pipe are captured in a D-entry FIFO and presented to a stallable valid/ready consumer. Credit accounting guarantees that every result has a free FIFO slot, so the delay pipe itself never needs backpressure.

## Interface

Parameters:

- N, 5: latency of the upstream delay pipe in cycles (issue to `in_vld`); N ≥ 0
- W, 32: data width
- D, N+2: FIFO depth, equal to the total credit count; D ≥ 1

Ports:

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_rdy  out  1  credit available; equals `credit_r != 0`
- issue  in  1  upstream issued one item into the delay pipe this cycle
- in_vld  in  1  item arriving from the delay pipe
- in  in  W  arriving data
- out_vld  out  1  FIFO not empty
- out  out  W  FIFO head data
- out_rdy  in  1  consumer accepts head
- credit_r  out  $clog2(D+1)  credits currently available
- err_r  out  1  sticky protocol error

## Operation

- Credit counter `credit_r`, reset to D.
  - Decrements on `issue`.
  - Increments on pop, where pop = `out_vld & out_rdy`.
  - Issue and pop in the same cycle leave it unchanged.
  - It never underflows below 0 and never exceeds D; a violating update saturates and sets `err_r`.
- FIFO: circular buffer of D entries with `wr_ptr` and `rd_ptr` in range 0..D-1, plus an occupancy count in range 0..D.
  - Both pointers wrap from D-1 to 0.
  - D=1 degenerates to a single register with no pointers.
- Push happens when `in_vld` is high.
  - Data is written at `wr_ptr`, which then advances.
  - Push while full (count == D) drops the data, holds the pointers and sets `err_r`.
- Pop happens when `out_vld & out_rdy`; `rd_ptr` advances.
- Simultaneous push and pop: both take effect and the count is unchanged. This is legal when full, because pop frees the slot in the same edge.
- `out` = `mem[rd_ptr]`. Its value is don't-care while `out_vld` = 0. Entry memory is not reset.
- `err_r` is sticky and set by any of:
  - `issue` while `issue_rdy` = 0
  - push while full without a simultaneous pop
  - pop-side credit overflow
  - It clears only on `rst`.
- Illegal `issue` does not change `credit_r`.
- Invariant, checked by assertion: `credit_r` + occupancy + items in flight == D.

## Timing

- Reset values: `issue_rdy` = 1 (D ≥ 1), `credit_r` = D, `out_vld` = 0, `err_r` = 0, pointers = 0, count = 0.
- Reset mid-operation: all state returns to its reset value on the next edge. Items in flight in the delay pipe are the issuer's responsibility to flush; the issuer's reset must be synchronous with this one.
- Arrival to output: `in_vld` at edge t gives `out_vld` = 1 from cycle t+1. There is no same-cycle bypass.
- Pop to credit: pop at cycle t raises `credit_r` and `issue_rdy` at cycle t+1.
- Issue to credit consumption: `issue` at cycle t lowers `credit_r` at t+1. `issue_rdy` is purely registered, so there is no combinational path from `issue` to `issue_rdy`.
- Round trip is N+2 cycles: issue at t, arrive at t+N, out at t+N+1, credit at t+N+2.
- Sustained one item per cycle requires D ≥ N+2 with `out_rdy` held at 1. A smaller D throttles throughput to D/(N+2).
- `out_rdy` may be deasserted arbitrarily. `out` and `out_vld` remain stable until pop.

## Test plan

- Streaming: N=5, D=7, `issue` every cycle while `issue_rdy`, `out_rdy`=1 → `issue_rdy` never drops, one `out_vld` per cycle after a 6-cycle fill, data in order, `err_r`=0.
- Backpressure fill: N=5, D=7, `out_rdy`=0, issue freely → exactly 7 issues are accepted, `issue_rdy`=0 after the 7th, and `out_vld` count reaches 7. Then `out_rdy`=1 → 7 pops in order, `credit_r` returns to 7.
- Simultaneous events: FIFO full, with push and pop in the same cycle → count stays D, no data lost. `issue` and pop in the same cycle → `credit_r` unchanged.
- Wrap-around: D=3 with 10 items and random `out_rdy` → pointers wrap 2→0 and data matches a scoreboard.
- Errors:
  - `issue` with `credit_r`=0 → `err_r`=1 next cycle, `credit_r` stays 0.
  - Forced `in_vld` while full with `out_rdy`=0 → `err_r`=1, head data unchanged.
- Reset mid-operation: 4 items buffered, assert `rst` for one cycle → next cycle `out_vld`=0, `credit_r`=D, `err_r`=0, `issue_rdy`=1. A subsequent stream passes cleanly.
